// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: entry layout, address
// field width helpers and the default reset PC.
package btb_pkg;

    // Number of index bits for a direct-mapped table of the given size.
    function automatic int btb_idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Tag bits left above the index once the two word-offset bits are dropped.
    function automatic int btb_tag_width(input int entries, input int xlen);
        return xlen - btb_idx_width(entries) - 2;
    endfunction

    localparam int          BTB_DEF_ENTRIES  = 16;
    localparam int          BTB_DEF_XLEN     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Logical layout of one entry in the default configuration.
    typedef struct packed {
        logic                                                  valid;
        logic [btb_tag_width(BTB_DEF_ENTRIES, BTB_DEF_XLEN)-1:0] tag;
        logic [BTB_DEF_XLEN-1:0]                               target;
    } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module btb_sat_counter
    import btb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    // Count qualifying events, holding once the maximum is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with a one-cycle registered
// lookup. Taken resolutions from execute fill the table; a taken update to
// the same index as a concurrent lookup is forwarded to that lookup.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int               ENTRIES  = BTB_DEF_ENTRIES,
    parameter int               XLEN     = BTB_DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    input  logic            predict,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    output logic            resp_valid,
    output logic            hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] next_pc,
    output logic [15:0]     lookup_count,
    output logic [15:0]     hit_count
);

    localparam int IDX_W = btb_idx_width(ENTRIES);
    localparam int TAG_W = btb_tag_width(ENTRIES, XLEN);

    // Valid bits live in a flat vector so they alone can be reset; tags and
    // targets are only meaningful once the matching valid bit is set.
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_write;
    logic             bypass;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_target;
    logic             lk_hit;
    logic             lk_taken;
    logic [XLEN-1:0]  lk_next;

    // Word-offset bits take no part in indexing or tagging.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx   = lookup_pc[IDX_W+1:2];
    assign lk_tag   = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx   = update_pc[IDX_W+1:2];
    assign up_tag   = update_pc[XLEN-1:IDX_W+2];
    assign up_write = update_valid & update_taken;
    assign bypass   = up_write & (up_idx == lk_idx);

    // Read the indexed entry, letting a same-index taken update win.
    always_comb begin
        rd_valid  = valid_q[lk_idx];
        rd_tag    = tag_q[lk_idx];
        rd_target = target_q[lk_idx];
        if (bypass) begin
            rd_valid  = 1'b1;
            rd_tag    = up_tag;
            rd_target = update_target;
        end
    end

    assign lk_hit   = rd_valid & (rd_tag == lk_tag);
    assign lk_taken = lk_hit & predict;
    assign lk_next  = lk_taken ? rd_target : (lookup_pc + XLEN'(4));

    // Set the valid bit of the entry written by a taken resolution.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (up_write) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Write tag and target for a taken resolution, replacing any alias.
    always_ff @(posedge clk) begin
        if (up_write) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= update_target;
        end
    end

    // Register the lookup response; idle cycles hold the last prediction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            pred_taken <= 1'b0;
            next_pc    <= RESET_PC;
        end else begin
            resp_valid <= lookup_valid;
            if (lookup_valid) begin
                hit        <= lk_hit;
                pred_taken <= lk_taken;
                next_pc    <= lk_next;
            end
        end
    end

    btb_sat_counter u_lookup_count (
        .clk   (clk),
        .reset (reset),
        .inc   (lookup_valid),
        .count (lookup_count)
    );

    btb_sat_counter u_hit_count (
        .clk   (clk),
        .reset (reset),
        .inc   (lookup_valid & lk_hit),
        .count (hit_count)
    );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16, XLEN=32).
module tb_branch_target_buffer;

    logic        clk;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        predict;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        resp_valid;
    logic        hit;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic [15:0] lookup_count;
    logic [15:0] hit_count;

    int errors = 0;
    int checks = 0;

    branch_target_buffer #(
        .ENTRIES  (16),
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .predict       (predict),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .resp_valid    (resp_valid),
        .hit           (hit),
        .pred_taken    (pred_taken),
        .next_pc       (next_pc),
        .lookup_count  (lookup_count),
        .hit_count     (hit_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic rv, input logic h, input logic pt,
                              input logic [31:0] npc, input logic [15:0] lc, input logic [15:0] hc);
        check({tag, ".resp_valid"},   {31'd0, resp_valid}, {31'd0, rv});
        check({tag, ".hit"},          {31'd0, hit},        {31'd0, h});
        check({tag, ".pred_taken"},   {31'd0, pred_taken}, {31'd0, pt});
        check({tag, ".next_pc"},      next_pc,             npc);
        check({tag, ".lookup_count"}, {16'd0, lookup_count}, {16'd0, lc});
        check({tag, ".hit_count"},    {16'd0, hit_count},    {16'd0, hc});
    endtask

    // Drivers: advance one edge, then sample 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lookup_valid  = 1'b0;
        lookup_pc     = 32'h0;
        predict       = 1'b0;
        update_valid  = 1'b0;
        update_pc     = 32'h0;
        update_target = 32'h0;
        update_taken  = 1'b0;
    endtask

    task automatic drive_lookup(input logic [31:0] pc, input logic pred);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        predict      = pred;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = taken;
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic pred);
        idle();
        drive_lookup(pc, pred);
        tick();
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        idle();
        drive_update(pc, tgt, taken);
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        check_resp("reset", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_resp("after_release", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);

        // Cold miss
        do_lookup(32'h100, 1'b1);
        check_resp("cold_miss", 1'b1, 1'b0, 1'b0, 32'h104, 16'd1, 16'd0);

        // Taken fill; idle lookup side drops resp_valid and holds next_pc
        do_update(32'h100, 32'h200, 1'b1);
        check_resp("fill_idle", 1'b0, 1'b0, 1'b0, 32'h104, 16'd1, 16'd0);

        do_lookup(32'h100, 1'b1);
        check_resp("hit_taken", 1'b1, 1'b1, 1'b1, 32'h200, 16'd2, 16'd1);

        do_lookup(32'h100, 1'b0);
        check_resp("hit_not_pred", 1'b1, 1'b1, 1'b0, 32'h104, 16'd3, 16'd2);

        // Not-taken update to index 0 must not disturb the entry
        do_update(32'h180, 32'h999, 1'b0);
        do_lookup(32'h100, 1'b1);
        check_resp("nt_retained", 1'b1, 1'b1, 1'b1, 32'h200, 16'd4, 16'd3);

        // Alias replacement on index 0
        do_update(32'h140, 32'h300, 1'b1);
        do_lookup(32'h100, 1'b1);
        check_resp("alias_evict", 1'b1, 1'b0, 1'b0, 32'h104, 16'd5, 16'd3);
        do_lookup(32'h140, 1'b1);
        check_resp("alias_new", 1'b1, 1'b1, 1'b1, 32'h300, 16'd6, 16'd4);

        // Write-first bypass: same index, same cycle
        idle();
        drive_update(32'h40, 32'h80, 1'b1);
        drive_lookup(32'h40, 1'b1);
        tick();
        check_resp("bypass", 1'b1, 1'b1, 1'b1, 32'h80, 16'd7, 16'd5);

        // Wrap of lookup_pc+4 on a miss (index 15 never written)
        do_lookup(32'hFFFF_FFFC, 1'b1);
        check_resp("wrap", 1'b1, 1'b0, 1'b0, 32'h0000_0000, 16'd8, 16'd5);

        // Update to a different index does not affect a concurrent lookup
        idle();
        drive_update(32'h44, 32'h500, 1'b1);
        drive_lookup(32'h40, 1'b1);
        tick();
        check_resp("indep_idx", 1'b1, 1'b1, 1'b1, 32'h80, 16'd9, 16'd6);
        do_lookup(32'h44, 1'b1);
        check_resp("indep_fill", 1'b1, 1'b1, 1'b1, 32'h500, 16'd10, 16'd7);

        // Idle cycle holds hit/pred_taken/next_pc
        idle();
        tick();
        check_resp("hold", 1'b0, 1'b1, 1'b1, 32'h500, 16'd10, 16'd7);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        check_resp("async_reset", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
        tick();
        #2;
        reset = 1'b1;
        tick();
        check_resp("post_reset_idle", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
        do_lookup(32'h100, 1'b1);
        check_resp("post_reset_miss", 1'b1, 1'b0, 1'b0, 32'h104, 16'd1, 16'd0);
        do_lookup(32'h40, 1'b1);
        check_resp("post_reset_miss2", 1'b1, 1'b0, 1'b0, 32'h44, 16'd2, 16'd0);

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-stage companion to the 2-bit direction predictor. The predictor supplies taken/not-taken; this block supplies the target and forms the predicted next fetch PC.
- Direct-mapped, tagged, 1-cycle registered lookup. Updated from execute when a branch resolves.
- Output feeds the fetch PC mux. Resolution results flow back to both this block and the direction predictor.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two, ≥2.
- XLEN, 32, PC/target width.
- RESET_PC, 32'h0000_0000, value of next_pc while in reset and before the first response.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  fetch requests a prediction for lookup_pc this cycle.
- lookup_pc  in  XLEN  fetch PC; word aligned, so bits [1:0] are ignored.
- predict  in  1  direction from the 2-bit predictor for lookup_pc, same cycle.
- update_valid  in  1  execute reports a resolved branch.
- update_pc  in  XLEN  PC of the resolved branch.
- update_target  in  XLEN  resolved target address.
- update_taken  in  1  resolved direction.
- resp_valid  out  1  response for the previous cycle's lookup.
- hit  out  1  tag match on a valid entry.
- pred_taken  out  1  hit & predict.
- next_pc  out  XLEN  predicted next fetch PC.
- lookup_count  out  16  lookups since reset; saturating.
- hit_count  out  16  hits since reset; saturating.

Behaviour:
- Address fields: IDX = log2(ENTRIES). index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2].
- Storage per entry: valid bit, tag, target. Only valid bits are reset; tag and target arrays need no reset.
- Reset (reset low, async):
  - All valid bits are cleared.
  - resp_valid, hit, pred_taken, lookup_count and hit_count go to 0.
  - next_pc goes to RESET_PC.
  - Takes effect immediately, including mid-operation. Outputs stay at reset values until the first lookup after release.
- Lookup:
  - Latency is exactly 1 cycle.
  - On a clock edge with lookup_valid=1, the block registers:
    - resp_valid=1
    - hit = valid[index] & (tag[index]==tag(lookup_pc))
    - pred_taken = hit & predict
    - next_pc = pred_taken ? target[index] : lookup_pc+4
  - lookup_pc+4 is modulo 2^XLEN (wraps).
  - predict is sampled in the same cycle as lookup_pc.
- lookup_valid=0: resp_valid goes to 0 on the next edge. hit, pred_taken and next_pc hold their previous values.
- Update, on an edge with update_valid=1:
  - update_taken=1: write valid=1, the tag and update_target into entry index(update_pc). This overwrites any aliasing entry (direct-mapped replacement).
  - update_taken=0: no write. An existing entry is retained; direction is owned by the predictor.
- Simultaneous lookup and taken update to the same index: the lookup is evaluated against the NEW entry (write-first bypass). Different indices are independent.
- Counters:
  - lookup_count increments on each lookup.
  - hit_count increments on each lookup that hits.
  - Both saturate at 16'hFFFF; they never wrap.

Decomposition:
- Shared package, btb_pkg, holds:
  - the entry struct typedef {valid, tag, target}
  - index/tag width functions derived from ENTRIES and XLEN
  - the RESET_PC default.
- One natural sub-module: btb_sat_counter (16-bit saturating incrementer, async active-low reset), instanced twice.
- Storage array, tag compare and next-PC mux stay in the top module.

Test Plan (ENTRIES=16):
- Cold miss: release reset; lookup 0x100 with predict=1. Next cycle: resp_valid=1, hit=0, pred_taken=0, next_pc=0x104, lookup_count=1, hit_count=0.
- Taken fill: update 0x100→0x200 taken. Then:
  - lookup 0x100 with predict=1 → hit=1, pred_taken=1, next_pc=0x200.
  - lookup 0x100 with predict=0 → hit=1, pred_taken=0, next_pc=0x104.
- Not-taken update: update 0x180 (index 0) taken=0. Then lookup 0x100 → still hit, next_pc=0x200 (entry retained, no write).
- Alias replacement: update 0x140→0x300 taken (same index 0, different tag). Then:
  - lookup 0x100 → hit=0, next_pc=0x104.
  - lookup 0x140 with predict=1 → next_pc=0x300.
- Bypass and wrap:
  - Same cycle: update 0x40→0x80 taken plus lookup 0x40 with predict=1 → next cycle hit=1, next_pc=0x80.
  - lookup 0xFFFF_FFFC miss → next_pc=0x0000_0000.
- Reset mid-operation: drive reset low between clock edges after fills. Immediately: hit=0, resp_valid=0, next_pc=RESET_PC, both counters=0. After release, lookup 0x100 → hit=0.
